sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Parametrised successor to the fixed five-sprite colour mapper.
- Composites NUM_SPRITES rectangular sprites over a selectable background, with per-sprite enable, size and transparency key.
- Pipeline delay is matched to the sprite/background ROM latency, and a per-frame sticky player-collision flag is produced.
- Sits between the VGA controller / sprite ROM mappers and the VGA DAC outputs.

Parameters:
- NUM_SPRITES, 5: sprite count. Index 0 is the player and has the highest priority; lower index wins.
- COORD_W, 10: width of coordinates and sizes.
- COLOR_W, 4: bits per channel of the ROM colour inputs (1..8).
- ROM_LAT, 1: cycles from coordinate presentation to valid ROM colour data (0..3).

Ports:
- vga_clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- DrawX, DrawY  in  COORD_W each  current pixel coordinate
- blank  in  1  1 = active video, 0 = blanking
- spr_x, spr_y  in  NUM_SPRITES*COORD_W  sprite top-left corners; sprite i occupies bits [i*COORD_W +: COORD_W]
- spr_w, spr_h  in  NUM_SPRITES*COORD_W  sprite sizes; 0 = never drawn
- spr_en  in  NUM_SPRITES  per-sprite enable
- spr_key  in  NUM_SPRITES*3*COLOR_W  per-sprite transparent colour, packed {r,g,b}
- spr_rgb  in  NUM_SPRITES*3*COLOR_W  sprite ROM colour, valid ROM_LAT cycles after coordinates
- bg_rgb, alt_bg_rgb  in  3*COLOR_W each  background / game-over ROM colour, same alignment as spr_rgb
- bg_sel  in  1  0 = bg_rgb, 1 = alt_bg_rgb
- collide_clr  in  1  clears collide
- spr_dx, spr_dy  out  NUM_SPRITES*COORD_W  combinational offsets DrawX-spr_x and DrawY-spr_y (mod 2^COORD_W), used as ROM addresses
- Red, Green, Blue  out  8 each  registered pixel colour
- hit_mask  out  NUM_SPRITES  registered; bit i = sprite i opaque at the output pixel
- frame_start  out  1  one-cycle pulse at the start of each frame
- collide  out  1  sticky player-collision flag

Behaviour:
- Reset (async, Reset_n=0): Red, Green, Blue, hit_mask, frame_start, collide, the frame accumulator and all delay-pipe stages are 0.
- Stage A (combinational):
  - in_box[i] = spr_en[i] && spr_dx[i] < spr_w[i] && spr_dy[i] < spr_h[i], using unsigned compare.
  - Negative offsets wrap to large values and therefore miss; no wrap-around drawing.
- Delay pipe: in_box and blank are delayed ROM_LAT cycles in shift registers so they align with spr_rgb and bg_rgb. With ROM_LAT=0 there is no delay.
- Stage B (combinational on aligned data):
  - opaque[i] = in_box_d[i] && spr_rgb[i] != spr_key[i].
  - The pixel source is the lowest-index opaque sprite. If none, the source is alt_bg_rgb when bg_sel=1, else bg_rgb.
  - bg_sel is not delayed; it is a frame-level mode bit.
- Output register:
  - Each channel is expanded to 8 bits by MSB replication, e.g. COLOR_W=4: 0xA -> 0xAA, 0xF -> 0xFF.
  - If blank_d=0, RGB = 0 regardless of sprites.
  - hit_mask <= opaque, forced to 0 when blank_d=0.
- Total latency: DrawX/DrawY to Red/Green/Blue = ROM_LAT+1 cycles.
- Frame detection:
  - DrawY is registered as prevY.
  - frame_start <= (DrawY==0 && prevY!=0), on undelayed inputs.
  - The first frame after reset does not pulse, because prevY is 0.
- Collision:
  - event = opaque[0] && |opaque[NUM_SPRITES-1:1] && blank_d.
  - On a non-frame_start cycle: acc <= acc | event.
  - On a cycle where frame_start is being asserted: collide <= collide | acc, then acc <= event (that pixel belongs to the new frame).
  - collide_clr=1 clears collide, except when a set occurs in the same cycle, in which case the set wins.
  - acc is unaffected by collide_clr.
  - collide therefore rises exactly at the frame boundary after the first overlapping frame.
- Sprites with equal coordinates: priority alone decides the pixel; all overlapping opaque bits still appear in hit_mask.
- Reset mid-frame: the pipe flushes to 0 and the output is black until ROM_LAT+1 cycles after release.

Test Plan:
- Priority:
  - Stimulus: ROM_LAT=1; sprites 0 and 2 both cover (100,100); spr_rgb[0]=0xF00, spr_rgb[2]=0x0F0; keys 0x000.
  - Response: two cycles after DrawX=100, DrawY=100 with blank=1, RGB = FF/00/00 and hit_mask = 00101.
- Transparency and background:
  - Stimulus: sprite 0 covers the pixel with spr_rgb[0]=spr_key[0]=0x0E0; bg_rgb=0x123, alt_bg_rgb=0xABC.
  - Response: bg_sel=0 gives 11/22/33; bg_sel=1 gives AA/BB/CC; hit_mask=0.
- Bounds, size and enable:
  - Stimulus: spr_x=600, spr_w=30, DrawX=629 then 630; then spr_en=0; then spr_w=0; then DrawX<spr_x.
  - Response: hit at 629 only; no hit in any of the other cases.
- Blanking:
  - Stimulus: blank=0 while a sprite is opaque.
  - Response: RGB=0 and hit_mask=0; blank=1 restores the sprite colour after ROM_LAT+1 cycles.
- Collision:
  - Stimulus: sprites 0 and 3 overlap in frame N only; then pulse collide_clr.
  - Response: collide stays 0 during frame N and rises on the frame_start cycle ending frame N. It stays 1 until collide_clr, then 0. collide_clr asserted on the frame_start cycle of a colliding frame leaves collide=1.
- Reset:
  - Stimulus: assert Reset_n=0 mid-line with opaque sprites.
  - Response: all outputs go to 0 immediately; after release, the first valid pixel appears ROM_LAT+1 cycles later and no frame_start pulses on the first frame.

Source files
------------

// File: rtl/sprite_compositor.sv
`default_nettype none
// ===========================================================================
// sprite_compositor : prioritised sprite/background mixer with collision flag
// Rev 1.0
// ===========================================================================
module sprite_compositor #(
   parameter int NUM_SPRITES = 5,
   parameter int COORD_W     = 10,
   parameter int COLOR_W     = 4,
   parameter int ROM_LAT     = 1
) (
   input  logic                               vga_clk,
   input  logic                               Reset_n,
   input  logic [COORD_W-1:0]                 DrawX,
   input  logic [COORD_W-1:0]                 DrawY,
   input  logic                               blank,
   input  logic [NUM_SPRITES*COORD_W-1:0]     spr_x,
   input  logic [NUM_SPRITES*COORD_W-1:0]     spr_y,
   input  logic [NUM_SPRITES*COORD_W-1:0]     spr_w,
   input  logic [NUM_SPRITES*COORD_W-1:0]     spr_h,
   input  logic [NUM_SPRITES-1:0]             spr_en,
   input  logic [NUM_SPRITES*3*COLOR_W-1:0]   spr_key,
   input  logic [NUM_SPRITES*3*COLOR_W-1:0]   spr_rgb,
   input  logic [3*COLOR_W-1:0]               bg_rgb,
   input  logic [3*COLOR_W-1:0]               alt_bg_rgb,
   input  logic                               bg_sel,
   input  logic                               collide_clr,
   output logic [NUM_SPRITES*COORD_W-1:0]     spr_dx,
   output logic [NUM_SPRITES*COORD_W-1:0]     spr_dy,
   output logic [7:0]                         Red,
   output logic [7:0]                         Green,
   output logic [7:0]                         Blue,
   output logic [NUM_SPRITES-1:0]             hit_mask,
   output logic                               frame_start,
   output logic                               collide
);
   localparam int CW3 = 3*COLOR_W;

   logic [NUM_SPRITES-1:0] in_box;
   logic [NUM_SPRITES-1:0] in_box_al;
   logic [NUM_SPRITES-1:0] opaque;
   logic                   blank_al;

   // Offsets wrap modulo 2^COORD_W, so pixels left/above a sprite fail the compare.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
         assign spr_dx[gi*COORD_W +: COORD_W] = DrawX - spr_x[gi*COORD_W +: COORD_W];
         assign spr_dy[gi*COORD_W +: COORD_W] = DrawY - spr_y[gi*COORD_W +: COORD_W];
         assign in_box[gi] = spr_en[gi]
                          && (spr_dx[gi*COORD_W +: COORD_W] < spr_w[gi*COORD_W +: COORD_W])
                          && (spr_dy[gi*COORD_W +: COORD_W] < spr_h[gi*COORD_W +: COORD_W]);
         assign opaque[gi] = in_box_al[gi]
                          && (spr_rgb[gi*CW3 +: CW3] != spr_key[gi*CW3 +: CW3]);
      end
   endgenerate

   generate
      if (ROM_LAT == 0) begin : g_nodelay
         assign in_box_al = in_box;
         assign blank_al  = blank;
      end else begin : g_delay
         logic [NUM_SPRITES-1:0] box_pipe_q [ROM_LAT];
         logic [NUM_SPRITES-1:0] box_pipe_d [ROM_LAT];
         logic [ROM_LAT-1:0]     blank_pipe_q;
         logic [ROM_LAT-1:0]     blank_pipe_d;

         always_comb begin
            box_pipe_d[0]   = in_box;
            blank_pipe_d[0] = blank;
            for (int k = 1; k < ROM_LAT; k++) begin
               box_pipe_d[k]   = box_pipe_q[k-1];
               blank_pipe_d[k] = blank_pipe_q[k-1];
            end
         end

         always_ff @(posedge vga_clk or negedge Reset_n) begin
            if (!Reset_n) begin
               for (int k = 0; k < ROM_LAT; k++) box_pipe_q[k] <= '0;
               blank_pipe_q <= '0;
            end else begin
               for (int k = 0; k < ROM_LAT; k++) box_pipe_q[k] <= box_pipe_d[k];
               blank_pipe_q <= blank_pipe_d;
            end
         end

         assign in_box_al = box_pipe_q[ROM_LAT-1];
         assign blank_al  = blank_pipe_q[ROM_LAT-1];
      end
   endgenerate

   function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
      logic [7:0] e;
      for (int j = 0; j < 8; j++) e[7-j] = c[COLOR_W-1-(j % COLOR_W)];
      return e;
   endfunction

   logic [CW3-1:0] src_rgb;
   always_comb begin
      src_rgb = bg_sel ? alt_bg_rgb : bg_rgb;
      // Walk from highest index down so the lowest opaque index wins.
      for (int i = NUM_SPRITES-1; i >= 0; i--) begin
         if (opaque[i]) src_rgb = spr_rgb[i*CW3 +: CW3];
      end
   end

   logic [7:0]             red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic [NUM_SPRITES-1:0] hit_q, hit_d;
   logic [COORD_W-1:0]     prev_y_q, prev_y_d;
   logic                   frame_start_q, frame_start_d;
   logic                   acc_q, acc_d;
   logic                   collide_q, collide_d;
   logic                   coll_evt;

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      hit_d   = '0;
      if (blank_al) begin
         red_d   = expand(src_rgb[3*COLOR_W-1 -: COLOR_W]);
         green_d = expand(src_rgb[2*COLOR_W-1 -: COLOR_W]);
         blue_d  = expand(src_rgb[COLOR_W-1:0]);
         hit_d   = opaque;
      end
      prev_y_d      = DrawY;
      frame_start_d = (DrawY == '0) && (prev_y_q != '0);
      coll_evt      = opaque[0] && (|opaque[NUM_SPRITES-1:1]) && blank_al;
      // The aligned pixel seen on a frame-start cycle is credited to the new frame.
      acc_d         = frame_start_d ? coll_evt : (acc_q | coll_evt);
      if (frame_start_d && acc_q) collide_d = 1'b1;
      else if (collide_clr)       collide_d = 1'b0;
      else                        collide_d = collide_q;
   end

   always_ff @(posedge vga_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         hit_q         <= '0;
         prev_y_q      <= '0;
         frame_start_q <= 1'b0;
         acc_q         <= 1'b0;
         collide_q     <= 1'b0;
      end else begin
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         hit_q         <= hit_d;
         prev_y_q      <= prev_y_d;
         frame_start_q <= frame_start_d;
         acc_q         <= acc_d;
         collide_q     <= collide_d;
      end
   end

   assign Red         = red_q;
   assign Green       = green_q;
   assign Blue        = blue_q;
   assign hit_mask    = hit_q;
   assign frame_start = frame_start_q;
   assign collide     = collide_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ===========================================================================
// tb_sprite_compositor : scoreboard bench for sprite_compositor
// Rev 1.0
// ===========================================================================
module tb_sprite_compositor;
   localparam int NS  = 5;
   localparam int CW  = 10;
   localparam int CLW = 4;
   localparam int LAT = 1;
   localparam int C3  = 3*CLW;

   logic              vga_clk = 1'b0;
   logic              Reset_n = 1'b0;
   logic [CW-1:0]     DrawX = '0, DrawY = '0;
   logic              blank = 1'b0;
   logic [NS*CW-1:0]  spr_x = '0, spr_y = '0, spr_w = '0, spr_h = '0;
   logic [NS-1:0]     spr_en = '0;
   logic [NS*C3-1:0]  spr_key = '0, spr_rgb = '0;
   logic [C3-1:0]     bg_rgb = '0, alt_bg_rgb = '0;
   logic              bg_sel = 1'b0, collide_clr = 1'b0;
   logic [NS*CW-1:0]  spr_dx, spr_dy;
   logic [7:0]        Red, Green, Blue;
   logic [NS-1:0]     hit_mask;
   logic              frame_start, collide;

   sprite_compositor #(.NUM_SPRITES(NS), .COORD_W(CW), .COLOR_W(CLW), .ROM_LAT(LAT)) dut (
      .vga_clk(vga_clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_en(spr_en),
      .spr_key(spr_key), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb), .alt_bg_rgb(alt_bg_rgb),
      .bg_sel(bg_sel), .collide_clr(collide_clr), .spr_dx(spr_dx), .spr_dy(spr_dy),
      .Red(Red), .Green(Green), .Blue(Blue), .hit_mask(hit_mask),
      .frame_start(frame_start), .collide(collide)
   );

   always #5 vga_clk = ~vga_clk;

   int cyc = 0;
   always @(posedge vga_clk) cyc <= cyc + 1;

   typedef struct { int due; int id; logic [23:0] rgb; logic [NS-1:0] hit; } pix_t;
   typedef struct { int due; int id; logic fs; logic col; } st_t;
   pix_t pq[$];
   st_t  sq[$];
   int total = 0, bad = 0, nid = 0;

   always @(negedge vga_clk) begin
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         pix_t p;
         p = pq.pop_front();
         total++;
         if (p.due != cyc || {Red, Green, Blue} !== p.rgb || hit_mask !== p.hit) begin
            bad++;
            $display("FAIL pix%0d cyc=%0d rgb got %h exp %h hit got %b exp %b",
                     p.id, cyc, {Red, Green, Blue}, p.rgb, hit_mask, p.hit);
         end
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         st_t s;
         s = sq.pop_front();
         total++;
         if (s.due != cyc || frame_start !== s.fs || collide !== s.col) begin
            bad++;
            $display("FAIL st%0d cyc=%0d frame_start got %b exp %b collide got %b exp %b",
                     s.id, cyc, frame_start, s.fs, collide, s.col);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   task automatic pix(input int x, input int y, input logic b, input logic [23:0] er,
                      input logic [NS-1:0] eh, input logic cs = 1'b0, input logic efs = 1'b0,
                      input logic ecol = 1'b0, input logic clr = 1'b0);
      @(posedge vga_clk);
      #1;
      DrawX       = CW'(x);
      DrawY       = CW'(y);
      blank       = b;
      collide_clr = clr;
      nid++;
      pq.push_back(pix_t'{due: cyc + LAT + 1, id: nid, rgb: er, hit: eh});
      if (cs) sq.push_back(st_t'{due: cyc + 1, id: nid, fs: efs, col: ecol});
   endtask

   // Two blanked pixels so configuration changes never touch a visible pixel.
   task automatic blanks();
      for (int n = 0; n < 2; n++) pix(0, 1, 1'b0, 24'h0, '0);
   endtask

   task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                          input logic en, input logic [C3-1:0] rgb, input logic [C3-1:0] key);
      spr_x[i*CW +: CW]  = CW'(x);
      spr_y[i*CW +: CW]  = CW'(y);
      spr_w[i*CW +: CW]  = CW'(w);
      spr_h[i*CW +: CW]  = CW'(h);
      spr_en[i]          = en;
      spr_rgb[i*C3 +: C3] = rgb;
      spr_key[i*C3 +: C3] = key;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && (pq.size() > 0 || sq.size() > 0); n++) @(negedge vga_clk);
      total++;
      if (pq.size() > 0 || sq.size() > 0) begin
         bad++;
         $display("FAIL drain pending got %0d exp 0", pq.size() + sq.size());
      end
   endtask

   initial begin
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      chk("rst_rgb", 64'({Red, Green, Blue}), 64'h0);
      chk("rst_hit", 64'(hit_mask), 64'h0);
      chk("rst_fs_col", 64'({frame_start, collide}), 64'h0);
      @(posedge vga_clk);
      #1;
      Reset_n = 1'b1;

      // Collision across frame boundaries
      blanks();
      set_spr(0, 10, 10, 10, 10, 1'b1, 12'hF00, 12'h000);
      set_spr(3, 15, 15, 10, 10, 1'b1, 12'h00F, 12'h000);
      bg_rgb = 12'h123; alt_bg_rgb = 12'hABC; bg_sel = 1'b0;
      pix(12, 12, 1, 24'hFF0000, 5'b00001, 1, 0, 0);
      pix(17, 17, 1, 24'hFF0000, 5'b01001, 1, 0, 0);
      pix(22, 22, 1, 24'h0000FF, 5'b01000, 1, 0, 0);
      pix(0, 30, 1, 24'h112233, 5'b00000, 1, 0, 0);
      pix(0, 0, 1, 24'h112233, 5'b00000, 1, 1, 1);
      pix(0, 1, 1, 24'h112233, 5'b00000, 1, 0, 1);
      pix(12, 12, 1, 24'hFF0000, 5'b00001, 1, 0, 1);
      pix(0, 40, 1, 24'h112233, 5'b00000, 1, 0, 1);
      pix(0, 41, 1, 24'h112233, 5'b00000, 1, 0, 0, 1);
      pix(0, 42, 1, 24'h112233, 5'b00000, 1, 0, 0);
      pix(0, 0, 1, 24'h112233, 5'b00000, 1, 1, 0);
      pix(0, 1, 1, 24'h112233, 5'b00000, 1, 0, 0);
      pix(17, 17, 1, 24'hFF0000, 5'b01001, 1, 0, 0);
      pix(0, 5, 1, 24'h112233, 5'b00000, 1, 0, 0);
      pix(0, 0, 1, 24'h112233, 5'b00000, 1, 1, 1, 1);
      pix(0, 1, 1, 24'h112233, 5'b00000, 1, 0, 1);

      // Priority, blanking, transparency fall-through
      blanks();
      set_spr(0, 90, 90, 20, 20, 1'b1, 12'hF00, 12'h000);
      set_spr(2, 95, 95, 10, 10, 1'b1, 12'h0F0, 12'h000);
      set_spr(3, 0, 0, 0, 0, 1'b0, 12'h000, 12'h000);
      pix(100, 100, 1, 24'hFF0000, 5'b00101);
      pix(92, 92, 1, 24'hFF0000, 5'b00001);
      pix(106, 100, 1, 24'hFF0000, 5'b00001);
      pix(200, 200, 1, 24'h112233, 5'b00000);
      pix(100, 100, 0, 24'h000000, 5'b00000);
      pix(100, 100, 1, 24'hFF0000, 5'b00101);
      blanks();
      spr_key[0 +: C3] = 12'hF00;
      pix(100, 100, 1, 24'h00FF00, 5'b00100);

      // Keyed sprite reveals the selected background
      blanks();
      set_spr(2, 95, 95, 10, 10, 1'b0, 12'h0F0, 12'h000);
      set_spr(0, 90, 90, 20, 20, 1'b1, 12'h0E0, 12'h0E0);
      pix(100, 100, 1, 24'h112233, 5'b00000);
      blanks();
      bg_sel = 1'b1;
      pix(100, 100, 1, 24'hAABBCC, 5'b00000);

      // Bounds, enable and zero size
      blanks();
      bg_sel = 1'b0;
      set_spr(0, 600, 10, 30, 5, 1'b1, 12'h00F, 12'h000);
      pix(629, 12, 1, 24'h0000FF, 5'b00001);
      pix(630, 12, 1, 24'h112233, 5'b00000);
      pix(599, 12, 1, 24'h112233, 5'b00000);
      #1;
      chk("dx_wrap", 64'(spr_dx[0 +: CW]), 64'd1023);
      pix(629, 15, 1, 24'h112233, 5'b00000);
      pix(600, 10, 1, 24'h0000FF, 5'b00001);
      blanks();
      spr_en[0] = 1'b0;
      pix(610, 12, 1, 24'h112233, 5'b00000);
      blanks();
      set_spr(0, 600, 10, 0, 5, 1'b1, 12'h00F, 12'h000);
      pix(600, 12, 1, 24'h112233, 5'b00000);

      // Asynchronous reset mid-line
      blanks();
      set_spr(0, 90, 90, 20, 20, 1'b1, 12'hF00, 12'h000);
      set_spr(2, 95, 95, 10, 10, 1'b1, 12'h0F0, 12'h000);
      pix(100, 100, 1, 24'hFF0000, 5'b00101);
      pix(100, 100, 1, 24'hFF0000, 5'b00101);
      drain();
      @(posedge vga_clk);
      #3;
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_rgb", 64'({Red, Green, Blue}), 64'h0);
      chk("mid_rst_hit", 64'(hit_mask), 64'h0);
      chk("mid_rst_fs_col", 64'({frame_start, collide}), 64'h0);
      repeat (2) @(posedge vga_clk);
      #1;
      Reset_n = 1'b1;
      DrawX = '0; DrawY = '0; blank = 1'b1;
      nid++;
      pq.push_back(pix_t'{due: cyc + LAT + 1, id: nid, rgb: 24'h112233, hit: '0});
      sq.push_back(st_t'{due: cyc + 1, id: nid, fs: 1'b0, col: 1'b0});
      @(posedge vga_clk);
      @(negedge vga_clk);
      chk("post_rst_black", 64'({Red, Green, Blue, hit_mask}), 64'h0);
      pix(100, 100, 1, 24'hFF0000, 5'b00101, 1, 0, 0);
      pix(100, 100, 1, 24'hFF0000, 5'b00101);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
